// File: rtl/ram_dma_pkg.sv
// Shared widths and controller state encoding for the RAM-to-RAM copy engine.
package ram_dma_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/ram_copy_dma_if.sv
// Request/status handshake plus the RAM4K-style memory port of the copy engine.
interface ram_copy_dma_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;
  logic              mem_load;
  logic [DATA_W-1:0] mem_out;

  // master is the copy engine; slave is the requester together with the RAM
  modport master (
    input  start, src, dst, len, mem_out,
    output busy, done, mem_address, mem_in, mem_load
  );
  modport slave (
    output start, src, dst, len, mem_out,
    input  busy, done, mem_address, mem_in, mem_load
  );
endinterface

// File: rtl/dma_addr_gen.sv
// Word-offset counter with wrapping source/destination address adders.
module dma_addr_gen import ram_dma_pkg::*; #(
  parameter int ADDR_W = ram_dma_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W:0]   len_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              last_o
);
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W+1:0] count_nxt;

  always_comb begin
    count_d = count_q;
    if (clr_i)      count_d = '0;
    else if (inc_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // One extra bit so count+1 cannot overflow when len is the full memory size
  assign count_nxt = {1'b0, count_q} + {{(ADDR_W+1){1'b0}}, 1'b1};
  assign last_o    = count_nxt >= {1'b0, len_i};
  assign rd_addr_o = src_i + count_q[ADDR_W-1:0];
  assign wr_addr_o = dst_i + count_q[ADDR_W-1:0];
endmodule

// File: rtl/ram_copy_dma.sv
// Single-port RAM block copier: one READ then one WRITE cycle per word, ascending offsets.
module ram_copy_dma import ram_dma_pkg::*; #(
  parameter int ADDR_W = ram_dma_pkg::ADDR_W,
  parameter int DATA_W = ram_dma_pkg::DATA_W
) (
  input  logic           clk,
  input  logic           reset,
  ram_copy_dma_if.master bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [ADDR_W:0]   len_q;
  logic [DATA_W-1:0] data_q;
  logic              accept, clr, inc, last;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              busy, done, mem_load;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;

  dma_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (clr),
    .inc_i     (inc),
    .src_i     (src_q),
    .dst_i     (dst_q),
    .len_i     (len_q),
    .rd_addr_o (rd_addr),
    .wr_addr_o (wr_addr),
    .last_o    (last)
  );

  assign accept = (state_q == S_IDLE) && bus.start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src_q <= bus.src;
        dst_q <= bus.dst;
        len_q <= bus.len;
      end
      if (state_q == S_READ) data_q <= bus.mem_out;
    end
  end

  // Memory port is driven purely from state so reset silences it immediately
  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    mem_load    = 1'b0;
    mem_address = '0;
    mem_in      = '0;
    clr         = 1'b0;
    inc         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          clr     = 1'b1;
          state_d = (bus.len != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        busy        = 1'b1;
        mem_address = rd_addr;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        busy        = 1'b1;
        mem_address = wr_addr;
        mem_in      = data_q;
        mem_load    = 1'b1;
        inc         = 1'b1;
        state_d     = last ? S_DONE : S_READ;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.mem_load    = mem_load;
  assign bus.mem_address = mem_address;
  assign bus.mem_in      = mem_in;
endmodule
